// File: rtl/fix_pkg.sv
// rtl/fix_pkg.sv - shared fixed-point types and constants for the divider datapath
package fix_pkg;
  localparam int FIX_FRAC = 32;
  localparam int FIX_W    = FIX_FRAC + 1;

  typedef logic [FIX_W-1:0] fix_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } div_state_e;

  localparam fix_t FIX_SAT = '1;

  // One cycle per quotient bit; the count value DIV_ITERS marks the completion cycle.
  localparam logic [5:0] DIV_ITERS = 6'd33;
endpackage

// File: rtl/fix_add.sv
// rtl/fix_add.sv - combinational unsigned Q1.32 adder with carry-out
module fix_add
  import fix_pkg::*;
(
  input  fix_t             addend1,
  input  fix_t             addend2,
  output logic [FIX_W:0]   sum
);

  // Full-width sum; the extra bit carries out instead of saturating.
  assign sum = {1'b0, addend1} + {1'b0, addend2};

endmodule

// File: rtl/fix_div_unit.sv
// rtl/fix_div_unit.sv - sequential restoring divider producing a Q0.33 quotient fraction
module fix_div_unit
  import fix_pkg::*;
#(
  parameter int W = FIX_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_start,
  input  logic [W-1:0] i_dividend,
  input  logic [W-1:0] i_divisor,
  output logic         o_complete,
  output logic [W-1:0] o_quotient_out_frac
);

  div_state_e   state;
  logic [5:0]   iter_cnt;
  logic [W:0]   rem_q;      // partial remainder, already shifted left for the next compare
  logic [W-1:0] divisor_q;
  logic         sat_q;      // dividend >= divisor or divisor == 0: force all-ones result
  logic [W:0]   sub_sum;
  logic         rem_ge;
  logic [W-1:0] rem_next;

  // rem_q[0] is always zero after the shift, so OR-ing in a one supplies the +1
  // of the two's-complement subtract without a separate carry input.
  fix_add u_sub (
    .addend1 (rem_q[W-1:0] | {{(W-1){1'b0}}, 1'b1}),
    .addend2 (~divisor_q),
    .sum     (sub_sum)
  );

  // Compare shifted remainder against divisor and pick the restored or reduced value.
  always_comb begin
    rem_ge   = rem_q[W] | sub_sum[W];
    rem_next = rem_ge ? sub_sum[W-1:0] : rem_q[W-1:0];
  end

  // Control FSM with registered completion flag and quotient shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= IDLE;
      iter_cnt            <= '0;
      rem_q               <= '0;
      divisor_q           <= '0;
      sat_q               <= 1'b0;
      o_complete          <= 1'b0;
      o_quotient_out_frac <= '0;
    end else if (i_start) begin
      state     <= BUSY;
      iter_cnt  <= '0;
      rem_q     <= {i_dividend, 1'b0};
      divisor_q <= i_divisor;
      sat_q     <= (i_divisor == '0) || (i_dividend >= i_divisor);
      // A start from DONE leaves the flag up for one cycle; it drops on the first BUSY edge.
      if (state == BUSY) begin
        o_complete <= 1'b0;
      end
    end else begin
      case (state)
        BUSY: begin
          if (iter_cnt == DIV_ITERS) begin
            state      <= DONE;
            o_complete <= 1'b1;
          end else begin
            o_complete          <= 1'b0;
            rem_q               <= {rem_next, 1'b0};
            o_quotient_out_frac <= {o_quotient_out_frac[W-2:0], rem_ge | sat_q};
            iter_cnt            <= iter_cnt + 6'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fix_div_unit.sv
// tb/tb_fix_div_unit.sv - self-checking bench for fix_div_unit and fix_add
module tb_fix_div_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        i_start = 1'b0;
  logic [32:0] i_dividend = '0;
  logic [32:0] i_divisor = '0;
  logic        o_complete;
  logic [32:0] o_quotient_out_frac;

  logic [32:0] add_a = '0;
  logic [32:0] add_b = '0;
  logic [33:0] add_s;

  int checks = 0;
  int failures = 0;
  int rise_cnt = 0;
  int lat;
  bit chk_en = 1'b0;
  bit prev_c = 1'b0;

  // reference model state
  bit          m_busy = 1'b0;
  int          m_cnt = 0;
  bit          m_complete = 1'b0;
  logic [32:0] m_q = '0;
  logic [32:0] m_dd = '0;
  logic [32:0] m_dv = '0;

  always #5 clk = ~clk;

  fix_div_unit #(.W(33)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .i_start             (i_start),
    .i_dividend          (i_dividend),
    .i_divisor           (i_divisor),
    .o_complete          (o_complete),
    .o_quotient_out_frac (o_quotient_out_frac)
  );

  fix_add u_add (
    .addend1 (add_a),
    .addend2 (add_b),
    .sum     (add_s)
  );

  function automatic logic [32:0] ref_div(input logic [32:0] dd, input logic [32:0] dv);
    logic [65:0] num;
    if (dv == 33'd0 || dd >= dv) return 33'h1_FFFF_FFFF;
    num = {dd, 33'd0};
    return 33'(num / {33'd0, dv});
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic do_start(input logic [32:0] dd, input logic [32:0] dv);
    @(negedge clk);
    i_dividend = dd;
    i_divisor  = dv;
    i_start    = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_done(output int l);
    l = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (o_complete === 1'b1) begin
        l = k;
        break;
      end
    end
    if (l == 0) l = 99;
  endtask

  // cycle-level behavioural model: result appears 34 edges after the last sampled start
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_busy = 1'b0;
        m_cnt = 0;
        m_complete = 1'b0;
      end else begin
        if (m_busy) m_complete = 1'b0;
        if (i_start) begin
          m_busy = 1'b1;
          m_cnt = 0;
          m_dd = i_dividend;
          m_dv = i_divisor;
        end else if (m_busy) begin
          m_cnt++;
          if (m_cnt == 34) begin
            m_busy = 1'b0;
            m_complete = 1'b1;
            m_q = ref_div(m_dd, m_dv);
          end
        end
      end
    end
  end

  // per-cycle comparison of DUT outputs against the model
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("complete_vs_model", 64'(o_complete), 64'(m_complete));
        if (m_complete) check("quotient_vs_model", 64'(o_quotient_out_frac), 64'(m_q));
        if (o_complete && !prev_c) rise_cnt++;
        prev_c = o_complete;
      end
    end
  end

  initial begin
    #1 rst_n = 1'b0;
    #2;
    check("reset_complete", 64'(o_complete), 64'd0);
    check("reset_quotient", 64'(o_quotient_out_frac), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // basic 0.5
    do_start(33'h0_0000_0400, 33'h0_0000_0800);
    wait_done(lat);
    check("lat_basic", 64'(lat), 64'd34);
    check("q_basic", 64'(o_quotient_out_frac), 64'h1_0000_0000);

    // map-typical
    do_start(33'd2034, 33'd5253);
    wait_done(lat);
    check("lat_map", 64'(lat), 64'd34);
    check("q_map", 64'(o_quotient_out_frac), 64'd3326085467);
    check("q_map_q032", 64'(o_quotient_out_frac[32:1]), 64'd1663042733);

    // saturation
    do_start(33'd5253, 33'd2034);
    wait_done(lat);
    check("lat_sat", 64'(lat), 64'd34);
    check("q_sat_ge", 64'(o_quotient_out_frac), 64'h1_FFFF_FFFF);
    do_start(33'd5, 33'd0);
    wait_done(lat);
    check("lat_sat_div0", 64'(lat), 64'd34);
    check("q_sat_div0", 64'(o_quotient_out_frac), 64'h1_FFFF_FFFF);

    // restart after 10 cycles
    rise_cnt = 0;
    do_start(33'd2034, 33'd5253);
    repeat (8) @(negedge clk);
    do_start(33'h0_0000_0400, 33'h0_0000_0800);
    wait_done(lat);
    check("lat_restart", 64'(lat), 64'd34);
    check("q_restart", 64'(o_quotient_out_frac), 64'h1_0000_0000);
    check("restart_one_rise", 64'(rise_cnt), 64'd1);

    // operand change without start
    do_start(33'd2034, 33'd5253);
    repeat (5) @(negedge clk);
    i_dividend = 33'd5253;
    i_divisor  = 33'd2034;
    wait_done(lat);
    check("lat_latch", 64'(lat), 64'd29);
    check("q_latch", 64'(o_quotient_out_frac), 64'd3326085467);

    // held start for three edges
    @(negedge clk);
    i_dividend = 33'h0_0000_0400;
    i_divisor  = 33'h0_0000_0800;
    i_start    = 1'b1;
    repeat (3) @(negedge clk);
    i_start = 1'b0;
    wait_done(lat);
    check("lat_held", 64'(lat), 64'd34);
    check("q_held", 64'(o_quotient_out_frac), 64'h1_0000_0000);

    // reset during busy
    do_start(33'd2034, 33'd5253);
    repeat (14) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_complete", 64'(o_complete), 64'd0);
    check("async_rst_quotient", 64'(o_quotient_out_frac), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("idle_after_rst", 64'(o_complete), 64'd0);
    do_start(33'd2034, 33'd5253);
    wait_done(lat);
    check("lat_after_rst", 64'(lat), 64'd34);
    check("q_after_rst", 64'(o_quotient_out_frac), 64'd3326085467);

    // adder
    add_a = 33'h1_FFFF_FFFF;
    add_b = 33'h0_0000_0001;
    #1;
    check("add_carry", 64'(add_s), 64'h2_0000_0000);
    add_a = 33'h0_8000_0000;
    add_b = 33'h0_8000_0000;
    #1;
    check("add_half", 64'(add_s), 64'h1_0000_0000);
    add_a = 33'h1_2345_6789;
    add_b = 33'h0_1111_1111;
    #1;
    check("add_mixed", 64'(add_s), 64'h1_3456_789A);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
